// File: rtl/ws2812_frame_tx_pkg.sv
// ws2812_frame_tx_pkg: shared FSM encoding and default 50 MHz WS2812 timing
package ws2812_frame_tx_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH} state_t;
   localparam int FRAME_W      = 24;
   localparam int DEF_NUM_LEDS = 8;
   localparam int DEF_IDX_W    = 3;
   localparam int DEF_T0H_CYC  = 20;
   localparam int DEF_T1H_CYC  = 40;
   localparam int DEF_BIT_CYC  = 63;
   localparam int DEF_RST_CYC  = 14000;
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/ws2812_frame_tx_bit_timer.sv
// ws2812_frame_tx_bit_timer: loadable down-counter, expire while the count sits at zero
module ws2812_frame_tx_bit_timer #(
   parameter int W       = 15,
   parameter int RST_VAL = 0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_expire
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst) r_cnt <= W'(RST_VAL);
      else if (i_load) r_cnt <= i_value;
      else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
   end
   assign o_expire = (r_cnt == '0);
endmodule

// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx: fetches one GRB frame per LED and drives it out as WS2812 pulses, then latches
module ws2812_frame_tx
   import ws2812_frame_tx_pkg::*;
#(
   parameter int NUM_LEDS = DEF_NUM_LEDS,
   parameter int IDX_W    = DEF_IDX_W,
   parameter int T0H_CYC  = DEF_T0H_CYC,
   parameter int T1H_CYC  = DEF_T1H_CYC,
   parameter int BIT_CYC  = DEF_BIT_CYC,
   parameter int RST_CYC  = DEF_RST_CYC
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [FRAME_W-1:0] i_frame_in,
   output logic [IDX_W-1:0]   o_led_idx,
   output logic               o_frame_rd,
   output logic               o_dout,
   output logic               o_busy,
   output logic               o_done
);
   localparam int CNT_W = $clog2(max2(RST_CYC, BIT_CYC) + 1);
   if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RST_CYC > 0 &&
         NUM_LEDS > 0 && (1 << IDX_W) >= NUM_LEDS)) begin : g_bad_params
      $error("ws2812_frame_tx: illegal timing or index parameters");
   end
   state_t               r_state, w_next;
   logic [FRAME_W-1:0]   r_shreg;
   logic [4:0]           r_bit_cnt;
   logic [IDX_W-1:0]     r_led_idx;
   logic                 r_from_low, r_dout, r_busy, r_done, r_frame_rd;
   logic                 w_dout, w_busy, w_done, w_frame_rd;
   logic                 w_expire, w_load, w_hi_bit, w_last_bit, w_last_led;
   logic [CNT_W-1:0]     w_value;
   assign w_last_bit = (r_bit_cnt == '0);
   assign w_last_led = (r_led_idx == IDX_W'(NUM_LEDS - 1));
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_LATCH;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_HIGH;
         S_HIGH:  w_next = w_expire ? S_LOW : S_HIGH;
         S_LOW:   w_next = !w_expire ? S_LOW : !w_last_bit ? S_HIGH : w_last_led ? S_LATCH : S_LOAD;
         S_LATCH: w_next = w_expire ? S_IDLE : S_LATCH;
         default: w_next = S_LATCH;
      endcase
   end
   always_comb begin
      w_dout     = (w_next == S_HIGH);
      w_busy     = (w_next != S_IDLE);
      w_frame_rd = (w_next == S_LOAD);
      w_done     = (r_state == S_LATCH) && (w_next == S_IDLE) && r_from_low;
   end
   // The high time of the bit about to start comes from frame_in on LOAD, else from the next shreg bit
   always_comb begin
      w_load   = (w_next != r_state);
      w_hi_bit = (r_state == S_LOAD) ? i_frame_in[FRAME_W-1] : r_shreg[FRAME_W-2];
      w_value  = (w_next == S_HIGH) ? (w_hi_bit ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1)) :
                 (w_next == S_LOW)  ? (r_shreg[FRAME_W-1] ? CNT_W'(BIT_CYC - T1H_CYC - 1)
                                                          : CNT_W'(BIT_CYC - T0H_CYC - 1)) :
                                      CNT_W'(RST_CYC - 1);
   end
   ws2812_frame_tx_bit_timer #(.W(CNT_W), .RST_VAL(RST_CYC - 1)) u_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (w_load),
      .i_value  (w_value),
      .o_expire (w_expire)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_led_idx  <= '0;
         r_from_low <= 1'b0;
         r_dout     <= 1'b0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_frame_rd <= 1'b0;
      end else begin
         r_dout     <= w_dout;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_frame_rd <= w_frame_rd;
         if (r_state == S_IDLE && w_next == S_LOAD) r_led_idx <= '0;
         if (r_state == S_LOAD) begin
            r_shreg   <= i_frame_in;
            r_bit_cnt <= 5'd23;
         end
         if (r_state == S_LOW && w_expire) begin
            if (!w_last_bit) begin
               r_shreg   <= {r_shreg[FRAME_W-2:0], 1'b0};
               r_bit_cnt <= r_bit_cnt - 5'd1;
            end else if (!w_last_led) r_led_idx <= r_led_idx + IDX_W'(1);
         end
         if (r_state == S_LOW && w_next == S_LATCH) r_from_low <= 1'b1;
         if (r_state == S_LATCH && w_expire) begin
            r_from_low <= 1'b0;
            r_led_idx  <= '0;
         end
      end
   end
   assign o_led_idx  = r_led_idx;
   assign o_frame_rd = r_frame_rd;
   assign o_dout     = r_dout;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
endmodule

// File: tb/tb_ws2812_frame_tx.sv
// tb_ws2812_frame_tx: table vectors, random refreshes against a waveform model, reset and start corner cases
module tb_ws2812_frame_tx;
   localparam int NUM_LEDS = 8, IDX_W = 3, T0H = 2, T1H = 4, BITC = 6, RSTC = 20;
   localparam int LED_CYC = 1 + 24 * BITC;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [23:0] frame_in, noise = '0;
   logic [IDX_W-1:0] led_idx;
   logic frame_rd, dout, busy, done;
   logic [23:0] frames [NUM_LEDS];
   int checks = 0, failures = 0;
   int meas_w [8];
   int meas_per_bad, last_lead, last_tail, act_frd, act_done;
   logic act_dout [$];
   typedef struct packed {logic dout; logic frd; logic busy; logic done; logic [IDX_W-1:0] idx;} cyc_t;
   cyc_t exp_q [$];
   typedef struct {logic [23:0] frame0; int w [8];} vec_t;
   vec_t tbl [4];

   always #5 clk = ~clk;
   always @(negedge clk) noise = $urandom;
   // Outside the fetch strobe the mux output is garbage, so a late sample would show up
   assign frame_in = frame_rd ? frames[led_idx] : noise;

   ws2812_frame_tx #(.NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W), .T0H_CYC(T0H), .T1H_CYC(T1H),
                     .BIT_CYC(BITC), .RST_CYC(RSTC)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_frame_in(frame_in),
      .o_led_idx(led_idx), .o_frame_rd(frame_rd), .o_dout(dout), .o_busy(busy), .o_done(done));

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic cyc_t mk(input logic d, input logic f, input logic b, input logic dn, input int i);
      return cyc_t'({d, f, b, dn, IDX_W'(i)});
   endfunction

   // Expected per-cycle outputs of one refresh, starting with the cycle after the start is taken
   task automatic build_refresh();
      exp_q.delete();
      for (int i = 0; i < NUM_LEDS; i++) begin
         exp_q.push_back(mk(0, 1, 1, 0, i));
         for (int b = 23; b >= 0; b--) begin
            int h;
            h = frames[i][b] ? T1H : T0H;
            repeat (h) exp_q.push_back(mk(1, 0, 1, 0, i));
            repeat (BITC - h) exp_q.push_back(mk(0, 0, 1, 0, i));
         end
      end
      repeat (RSTC) exp_q.push_back(mk(0, 0, 1, 0, NUM_LEDS - 1));
      exp_q.push_back(mk(0, 0, 0, 1, 0));
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 3000 && busy !== 1'b0; n++) @(negedge clk);
      cmp("wait for idle", {31'd0, busy}, 0);
   endtask

   task automatic run_refresh(input bit skip_start, input bit hold, input int p1, input int p2);
      int bad, first;
      cyc_t a, fa, fe;
      bad = 0; first = -1; fa = '0; fe = '0;
      build_refresh();
      act_dout.delete(); act_frd = 0; act_done = 0;
      if (!skip_start) begin
         wait_idle();
         start = 1'b1;
         @(posedge clk);
         #1 start = hold;
      end
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         a = cyc_t'({dout, frame_rd, busy, done, led_idx});
         act_dout.push_back(dout);
         act_frd += int'(frame_rd);
         act_done += int'(done);
         if (a !== exp_q[k]) begin
            if (bad == 0) begin first = k; fa = a; fe = exp_q[k]; end
            bad++;
         end
         start = hold | (k == p1) | (k == p2);
      end
      if (bad != 0) $display("first waveform difference at cycle %0d: got %h expected %h", first, fa, fe);
      cmp("refresh waveform bad cycles", bad, 0);
      cmp("frame_rd strobes per refresh", act_frd, NUM_LEDS);
      cmp("done pulses per refresh", act_done, 1);
      last_lead = 0;
      while (last_lead < act_dout.size() && !act_dout[last_lead]) last_lead++;
      last_tail = 0;
      while (last_tail < act_dout.size() && !act_dout[act_dout.size() - 1 - last_tail]) last_tail++;
   endtask

   task automatic measure();
      int rise [$];
      meas_per_bad = 0;
      for (int k = 0; k < act_dout.size(); k++)
         if (act_dout[k] && (k == 0 || !act_dout[k - 1])) rise.push_back(k);
      for (int j = 0; j < 8; j++) begin
         meas_w[j] = 0;
         if (j < rise.size())
            for (int k = rise[j]; k < act_dout.size() && act_dout[k]; k++) meas_w[j]++;
         if (j > 0 && j < rise.size() && rise[j] - rise[j - 1] != BITC) meas_per_bad++;
      end
      if (rise.size() < 8) meas_per_bad++;
   endtask

   task automatic count_flush(output int nbusy, output int ndone);
      nbusy = 0; ndone = 0;
      for (int k = 0; k < 200; k++) begin
         if (busy !== 1'b1) break;
         nbusy++;
         ndone += int'(done);
         @(negedge clk);
      end
      ndone += int'(done);
   endtask

   initial begin
      int nb, nd, extra, tail1, hl;
      logic [31:0] wa, we;
      tbl[0].frame0 = 24'hA50000; tbl[0].w = '{4, 2, 4, 2, 2, 4, 2, 4};
      tbl[1].frame0 = 24'hFFFFFF; tbl[1].w = '{4, 4, 4, 4, 4, 4, 4, 4};
      tbl[2].frame0 = 24'h000000; tbl[2].w = '{2, 2, 2, 2, 2, 2, 2, 2};
      tbl[3].frame0 = 24'h0F00F1; tbl[3].w = '{2, 2, 2, 2, 4, 4, 4, 4};
      for (int i = 0; i < NUM_LEDS; i++) frames[i] = 24'(i * 24'h111111);

      // reset for two cycles, then a 20-cycle flush with no done
      @(posedge clk);
      @(negedge clk);
      cmp("reset dout", {31'd0, dout}, 0);
      cmp("reset busy", {31'd0, busy}, 1);
      cmp("reset done", {31'd0, done}, 0);
      cmp("reset frame_rd", {31'd0, frame_rd}, 0);
      cmp("reset led_idx", {29'd0, led_idx}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      count_flush(nb, nd);
      cmp("post-reset flush busy cycles", nb, RSTC);
      cmp("post-reset flush done pulses", nd, 0);

      // table: LED0 frame fixes the first-byte pulse widths
      for (int t = 0; t < 4; t++) begin
         frames[0] = tbl[t].frame0;
         for (int i = 1; i < NUM_LEDS; i++) frames[i] = 24'($urandom);
         run_refresh(0, 0, -1, -1);
         measure();
         wa = '0; we = '0;
         for (int j = 0; j < 8; j++) begin
            wa = (wa << 4) | 32'(meas_w[j] & 15);
            we = (we << 4) | 32'(tbl[t].w[j]);
         end
         cmp("led0 first-byte high widths", wa, we);
         cmp("led0 bit periods off", meas_per_bad, 0);
      end

      // start pulsed mid-bit and on the final latch cycle is ignored
      for (int i = 0; i < NUM_LEDS; i++) frames[i] = 24'($urandom);
      run_refresh(0, 0, 100, NUM_LEDS * LED_CYC + RSTC - 1);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         extra += int'(busy) + int'(done);
      end
      cmp("idle after refresh with ignored starts", extra, 0);

      // random frames, random ignored start pulses and idle gaps
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NUM_LEDS; i++) frames[i] = 24'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run_refresh(0, 0, $urandom_range(0, NUM_LEDS * LED_CYC - 1),
                     $urandom_range(NUM_LEDS * LED_CYC, NUM_LEDS * LED_CYC + RSTC - 1));
      end

      // reset while LED3 bit 10 is high
      for (int i = 0; i < NUM_LEDS; i++) frames[i] = 24'($urandom) | 24'h000400;
      wait_idle();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3 * LED_CYC + 1 + 13 * BITC + 1) @(negedge clk);
      cmp("pre-reset dout high", {31'd0, dout}, 1);
      cmp("pre-reset led_idx", {29'd0, led_idx}, 3);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      cmp("mid-op reset dout", {31'd0, dout}, 0);
      cmp("mid-op reset led_idx", {29'd0, led_idx}, 0);
      cmp("mid-op reset frame_rd", {31'd0, frame_rd}, 0);
      count_flush(nb, nd);
      cmp("mid-op reset flush busy cycles", nb, RSTC);
      cmp("mid-op reset flush done pulses", nd, 0);

      // start held high: latch plus the accepting idle cycle sit between refreshes
      for (int i = 0; i < NUM_LEDS; i++) frames[i] = 24'($urandom);
      hl = frames[NUM_LEDS - 1][0] ? T1H : T0H;
      run_refresh(0, 1, -1, -1);
      tail1 = last_tail;
      run_refresh(1, 1, -1, -1);
      cmp("held start gap low cycles", tail1 + last_lead - (BITC - hl + 1), RSTC + 1);
      tail1 = last_tail;
      run_refresh(1, 0, -1, -1);
      cmp("held start second gap low cycles", tail1 + last_lead - (BITC - hl + 1), RSTC + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
